// File: rtl/max_pool_window_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// max_pool_window_ctrl: line-buffered WIN_SIZE x WIN_SIZE window sequencer
// feeding max_pool_core. Optional feature macro: MAX_POOL_CTRL_SOF_CHK_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module max_pool_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_SIZE   = 3,
  parameter int STRIDE     = 2,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     s_vld,
  output logic                                     s_rdy,
  input  logic                                     s_sof,
  input  logic [DATA_WIDTH-1:0]                    s_data,
  input  logic                                     m_rdy,
  output logic                                     win_vld,
  output logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0]  win,
  output logic                                     frame_done
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
  ,
  output logic                                     sof_err
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int NB = WIN_SIZE - 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(WIN_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(WIN_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic accept, process, restart, last_px, emit;
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
  logic err_set;
`endif

  logic [RW-1:0] row, cur_row, row_nxt;
  logic [CW-1:0] col, cur_col, col_nxt;
  logic [PW-1:0] rph, cur_rph, rph_nxt;
  logic [PW-1:0] cph, cur_cph, cph_nxt;

  logic [DATA_WIDTH-1:0] lb     [NB][IMG_W];
  logic [DATA_WIDTH-1:0] sr     [WIN_SIZE][WIN_SIZE];
  logic [DATA_WIDTH-1:0] sr_nxt [WIN_SIZE][WIN_SIZE];
  logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0] win_nxt;

  // A held window blocks the pixel stream so the shift register cannot run ahead.
  assign s_rdy      = !(win_vld && !m_rdy);
  assign accept     = s_vld && s_rdy;
  assign frame_done = (state == DONE);
  // A restarted pixel sits at (0,0), so it can never be the frame's last pixel.
  assign last_px    = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    process   = 1'b0;
    restart   = 1'b0;
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
    err_set   = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept && s_sof) begin
          process   = 1'b1;
          restart   = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL, RUN: begin
        if (state == FILL && row == ROW_WIN) state_nxt = RUN;
        if (accept) begin
          process = 1'b1;
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
          if (s_sof) begin
            restart   = 1'b1;
            err_set   = 1'b1;
            state_nxt = FILL;
          end else if (last_px) begin
            state_nxt = DONE;
          end
`else
          if (last_px) state_nxt = DONE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position of the pixel being taken this cycle, and where the next one lands.
  always_comb begin
    cur_row = restart ? '0 : row;
    cur_col = restart ? '0 : col;
    cur_rph = restart ? '0 : rph;
    cur_cph = restart ? '0 : cph;

    col_nxt = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
    cph_nxt = (col_nxt == COL_WIN || cur_cph == PH_LAST) ? '0 : cur_cph + 1'b1;
    row_nxt = cur_row;
    rph_nxt = cur_rph;
    if (cur_col == COL_LAST) begin
      row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      rph_nxt = (row_nxt == ROW_WIN || cur_rph == PH_LAST) ? '0 : cur_rph + 1'b1;
    end

    emit = process && (cur_row >= ROW_WIN) && (cur_col >= COL_WIN) &&
           (cur_rph == '0) && (cur_cph == '0);
  end

  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int c = 0; c < WIN_SIZE - 1; c++) sr_nxt[r][c] = sr[r][c+1];
    end
    for (int r = 0; r < NB; r++) sr_nxt[r][WIN_SIZE-1] = lb[r][cur_col];
    sr_nxt[NB][WIN_SIZE-1] = s_data;
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int c = 0; c < WIN_SIZE; c++) begin
        win_nxt[(r*WIN_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = sr_nxt[r][c];
      end
    end
  end

  // Pixel storage is data-path only and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (process) begin
      for (int r = 0; r < NB - 1; r++) lb[r][cur_col] <= lb[r+1][cur_col];
      lb[NB-1][cur_col] <= s_data;
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE; c++) sr[r][c] <= sr_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row     <= '0;
      col     <= '0;
      rph     <= '0;
      cph     <= '0;
      win_vld <= 1'b0;
      win     <= '0;
    end else begin
      if (process) begin
        row <= row_nxt;
        col <= col_nxt;
        rph <= rph_nxt;
        cph <= cph_nxt;
      end
      if (emit) begin
        win_vld <= 1'b1;
        win     <= win_nxt;
      end else if (m_rdy) begin
        win_vld <= 1'b0;
      end
    end
  end

`ifdef MAX_POOL_CTRL_SOF_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     sof_err <= 1'b0;
    else if (err_set) sof_err <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_max_pool_window_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_max_pool_window_ctrl: scoreboard bench, 5x5 frames, STRIDE 2 and STRIDE 1
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_max_pool_window_ctrl;

  localparam int D  = 8;
  localparam int WB = 9 * D;

  typedef struct packed {
    logic          sel;
    logic [WB-1:0] w;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    vld;
  logic          s_sof;
  logic [D-1:0]  s_data;
  logic          m_rdy;
  logic          rdy0, rdy1, wvld0, wvld1, fd0, fd1;
  logic [WB-1:0] win0, win1;
  logic [1:0]    rdy, wvld, fdone;
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
  logic          serr0, serr1;
`endif

  always #5 clk = ~clk;

  assign rdy   = {rdy1, rdy0};
  assign wvld  = {wvld1, wvld0};
  assign fdone = {fd1, fd0};

  max_pool_window_ctrl #(.DATA_WIDTH(D), .WIN_SIZE(3), .STRIDE(2), .IMG_W(5), .IMG_H(5)) dut_s2 (
    .clk(clk), .reset_n(reset_n), .s_vld(vld[0]), .s_rdy(rdy0), .s_sof(s_sof), .s_data(s_data),
    .m_rdy(m_rdy), .win_vld(wvld0), .win(win0), .frame_done(fd0)
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
    , .sof_err(serr0)
`endif
  );

  max_pool_window_ctrl #(.DATA_WIDTH(D), .WIN_SIZE(3), .STRIDE(1), .IMG_W(5), .IMG_H(5)) dut_s1 (
    .clk(clk), .reset_n(reset_n), .s_vld(vld[1]), .s_rdy(rdy1), .s_sof(s_sof), .s_data(s_data),
    .m_rdy(m_rdy), .win_vld(wvld1), .win(win1), .frame_done(fd1)
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
    , .sof_err(serr1)
`endif
  );

  ent_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            nwin[2];
  int            fd_cnt[2];
  logic [1:0]    exp_wv, fd_pend;
  logic          mon_en, pend_push, pend_last;
  logic [WB-1:0] pend_win, mon_w;
  ent_t          mon_e;
  logic [D-1:0]  img[5][5];

  // Expected windows are queued when their completing pixel is accepted and
  // compared when the DUT hands a window downstream.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        mon_w = (k == 0) ? win0 : win1;
        n_cmp++;
        if (wvld[k] !== exp_wv[k]) begin
          n_err++;
          $display("FAIL win_vld dut%0d @%0t: got %b want %b", k, $time, wvld[k], exp_wv[k]);
        end
        n_cmp++;
        if (fdone[k] !== fd_pend[k]) begin
          n_err++;
          $display("FAIL frame_done dut%0d @%0t: got %b want %b", k, $time, fdone[k], fd_pend[k]);
        end
        if (fdone[k] === 1'b1) fd_cnt[k]++;
        if (wvld[k] === 1'b1 && m_rdy) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL extra_window dut%0d @%0t: got %h want none", k, $time, mon_w);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.sel !== k[0] || mon_w !== mon_e.w) begin
              n_err++;
              $display("FAIL window dut%0d @%0t: got %h want %h (dut%0d)", k, $time, mon_w, mon_e.w, mon_e.sel);
            end
          end
          nwin[k]++;
        end
        exp_wv[k]  = exp_wv[k] && !m_rdy;
        fd_pend[k] = 1'b0;
        if (vld[k] && rdy[k] === 1'b1) begin
          fd_pend[k] = pend_last;
          if (pend_push) begin
            mon_e.sel = k[0];
            mon_e.w   = pend_win;
            sb.push_back(mon_e);
            exp_wv[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input int sel, input logic [D-1:0] d, input logic sof,
                         input logic push, input logic [WB-1:0] w, input logic last);
    logic acc;
    vld       = '0;
    vld[sel]  = 1'b1;
    s_data    = d;
    s_sof     = sof;
    pend_push = push;
    pend_win  = w;
    pend_last = last;
    acc       = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      acc = (rdy[sel] === 1'b1);
      tick();
    end
    vld       = '0;
    s_sof     = 1'b0;
    pend_push = 1'b0;
    pend_last = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: got no s_rdy want accept within 64 cycles", sel);
    end
  endtask

  // mode 0: pixel = row*5+col, mode 1: random bytes (exercises sign bits)
  task automatic send_frame(input int sel, input int stride, input int mode, input int npix);
    int r, c;
    logic [D-1:0]  d;
    logic          push;
    logic [WB-1:0] w;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / 5;
      c = idx % 5;
      d = (mode == 0) ? D'(r * 5 + c) : D'($urandom);
      img[r][c] = d;
      push = (r >= 2) && (c >= 2) && ((r - 2) % stride == 0) && ((c - 2) % stride == 0);
      w = '0;
      if (push) begin
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            w[((wr * 3) + wc) * D +: D] = img[r - 2 + wr][c - 2 + wc];
      end
      send_px(sel, d, idx == 0, push, w, idx == 24);
    end
  endtask

  task automatic test_reset();
    logic [WB-1:0] w;
    tick();
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? win0 : win1;
      n_cmp += 4;
      if (wvld[k] !== 1'b0) begin n_err++; $display("FAIL reset_win_vld dut%0d: got %b want 0", k, wvld[k]); end
      if (fdone[k] !== 1'b0) begin n_err++; $display("FAIL reset_frame_done dut%0d: got %b want 0", k, fdone[k]); end
      if (rdy[k] !== 1'b1) begin n_err++; $display("FAIL reset_s_rdy dut%0d: got %b want 1", k, rdy[k]); end
      if (w !== '0) begin n_err++; $display("FAIL reset_win dut%0d: got %h want 0", k, w); end
    end
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
    n_cmp++;
    if ({serr1, serr0} !== 2'b00) begin n_err++; $display("FAIL reset_sof_err: got %b want 00", {serr1, serr0}); end
`endif
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic check_counts(input string name, input int sel, input int w0, input int f0,
                              input int wexp, input int fexp);
    repeat (4) tick();
    n_cmp += 3;
    if (nwin[sel] - w0 !== wexp) begin
      n_err++;
      $display("FAIL %s_windows: got %0d want %0d", name, nwin[sel] - w0, wexp);
    end
    if (fd_cnt[sel] - f0 !== fexp) begin
      n_err++;
      $display("FAIL %s_frame_done_count: got %0d want %0d", name, fd_cnt[sel] - f0, fexp);
    end
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL %s_pending: got %0d want 0", name, sb.size());
    end
  endtask

  task automatic test_stride2();
    int w0 = nwin[0], f0 = fd_cnt[0];
    send_frame(0, 2, 0, 25);
    check_counts("stride2", 0, w0, f0, 4, 1);
  endtask

  task automatic test_stride1();
    int w0 = nwin[1], f0 = fd_cnt[1];
    send_frame(1, 1, 0, 25);
    check_counts("stride1", 1, w0, f0, 9, 1);
  endtask

  task automatic test_backpressure();
    int w0 = nwin[0], f0 = fd_cnt[0];
    int t;
    logic [WB-1:0] held;
    fork
      send_frame(0, 2, 0, 25);
      begin
        t = 0;
        while (wvld[0] !== 1'b1 && t < 200) begin tick(); t++; end
        n_cmp++;
        if (wvld[0] !== 1'b1) begin
          n_err++;
          $display("FAIL bp_first_window: got win_vld %b want 1 within 200 cycles", wvld[0]);
        end
        m_rdy = 1'b0;
        held  = win0;
        repeat (3) begin
          @(negedge clk);
          n_cmp += 2;
          if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL bp_s_rdy: got %b want 0", rdy[0]); end
          if (win0 !== held || wvld[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: got %h/%b want %h/1", win0, wvld[0], held);
          end
        end
        tick();
        m_rdy = 1'b1;
      end
    join
    check_counts("backpressure", 0, w0, f0, 4, 1);
  endtask

  task automatic test_idle_drop();
    int w0 = nwin[0], f0 = fd_cnt[0];
    for (int i = 0; i < 6; i++) send_px(0, D'(100 + i), 1'b0, 1'b0, '0, 1'b0);
    check_counts("idle_drop", 0, w0, f0, 0, 0);
    w0 = nwin[0];
    f0 = fd_cnt[0];
    send_frame(0, 2, 0, 25);
    check_counts("after_idle", 0, w0, f0, 4, 1);
  endtask

  task automatic test_back_to_back();
    int w0 = nwin[0], f0 = fd_cnt[0];
    send_frame(0, 2, 1, 25);
    send_frame(0, 2, 1, 25);
    check_counts("back_to_back", 0, w0, f0, 8, 2);
  endtask

`ifdef MAX_POOL_CTRL_SOF_CHK_EN
  task automatic test_sof_restart();
    int w0 = nwin[0], f0 = fd_cnt[0];
    send_frame(0, 2, 0, 7);
    send_frame(0, 2, 0, 25);
    check_counts("sof_restart", 0, w0, f0, 4, 1);
    n_cmp++;
    if ({serr1, serr0} !== 2'b01) begin n_err++; $display("FAIL sof_err: got %b want 01", {serr1, serr0}); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int w0, f0;
    send_frame(0, 2, 0, 13);
    n_cmp++;
    if (wvld[0] !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", wvld[0]); end
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp += 2;
    if (wvld[0] !== 1'b0) begin n_err++; $display("FAIL mid_reset_win_vld: got %b want 0", wvld[0]); end
    if (win0 !== '0) begin n_err++; $display("FAIL mid_reset_win: got %h want 0", win0); end
    sb.delete();
    exp_wv  = '0;
    fd_pend = '0;
    tick();
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;
    w0 = nwin[0];
    f0 = fd_cnt[0];
    send_frame(0, 2, 0, 25);
    check_counts("after_reset", 0, w0, f0, 4, 1);
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
    n_cmp++;
    if (serr0 !== 1'b0) begin n_err++; $display("FAIL sof_err_cleared: got %b want 0", serr0); end
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    vld       = '0;
    s_sof     = 1'b0;
    s_data    = '0;
    m_rdy     = 1'b1;
    mon_en    = 1'b0;
    pend_push = 1'b0;
    pend_last = 1'b0;
    pend_win  = '0;
    exp_wv    = '0;
    fd_pend   = '0;
    nwin      = '{0, 0};
    fd_cnt    = '{0, 0};
    repeat (3) @(posedge clk);
    test_reset();
    test_stride2();
    test_stride1();
    test_backpressure();
    test_idle_drop();
    test_back_to_back();
`ifdef MAX_POOL_CTRL_SOF_CHK_EN
    test_sof_restart();
`endif
    test_reset_mid_frame();
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
